elevator_scheduler: RTL

Request-scheduling and motion stage of the elevator controller, directly upstream of the floor comparator. It latches floor calls into a pending bitmap and tracks the car position. It selects the next target floor by a SCAN (continue-in-direction) policy and drives motor and door outputs. `current_floor` and `target_floor` feed the comparator's two operands; arrival is also detected internally so the block is self-contained.

---
 rtl/elevator_pkg.sv | 19 +
 rtl/elevator_scheduler_floor_select.sv | 56 +++++
 rtl/elevator_scheduler.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator controller: FSM state encoding, travel
// direction and the floor index width shared with the downstream comparator.
package elevator_pkg;

  localparam int unsigned DefaultFw = 4;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StMoveUp   = 2'd1,
    StMoveDown = 2'd2,
    StDoorOpen = 2'd3
  } state_e;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

endpackage

// File: rtl/elevator_scheduler_floor_select.sv
// Combinational SCAN search: flags pending calls above/below the car and picks the
// nearest one in the travel direction, falling back to the opposite direction.
module floor_select
  import elevator_pkg::*;
#(
  parameter int unsigned FLOORS = 16,
  parameter int unsigned FW     = DefaultFw
) (
  input  logic [FLOORS-1:0] pending,
  input  logic [FW-1:0]     current_floor,
  input  logic              dir,
  output logic              any_above,
  output logic              any_below,
  output logic [FW-1:0]     target
);

  logic [FW-1:0] above_floor;
  logic [FW-1:0] below_floor;

  always_comb begin
    any_above   = 1'b0;
    any_below   = 1'b0;
    above_floor = current_floor;
    below_floor = current_floor;
    // Descending scan: the last hit is the lowest floor above the car.
    for (int i = int'(FLOORS) - 1; i >= 0; i--) begin
      if (pending[i] && (i > int'(current_floor))) begin
        any_above   = 1'b1;
        above_floor = FW'(i);
      end
    end
    // Ascending scan: the last hit is the highest floor below the car.
    for (int i = 0; i < int'(FLOORS); i++) begin
      if (pending[i] && (i < int'(current_floor))) begin
        any_below   = 1'b1;
        below_floor = FW'(i);
      end
    end

    target = current_floor;
    if (dir == DirUp) begin
      if (any_above) begin
        target = above_floor;
      end else if (any_below) begin
        target = below_floor;
      end
    end else begin
      if (any_below) begin
        target = below_floor;
      end else if (any_above) begin
        target = above_floor;
      end
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// Elevator request scheduler: latches floor calls, runs the SCAN motion FSM and
// drives motor/door outputs plus the comparator operands.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned FLOORS      = 16,
  parameter int unsigned FW          = DefaultFw,
  parameter int unsigned MOVE_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [FW-1:0]     req_floor,
  output logic [FW-1:0]     current_floor,
  output logic [FW-1:0]     target_floor,
  output logic              motor_up,
  output logic              motor_down,
  output logic              door_open,
  output logic [FLOORS-1:0] pending,
  output logic              busy
);

  localparam int unsigned MCW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int unsigned DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [MCW-1:0] MoveLast = MCW'(MOVE_CYCLES - 1);
  localparam logic [DCW-1:0] DoorLast = DCW'(DOOR_CYCLES - 1);

  state_e            state_q, state_d;
  dir_e              dir_q, dir_d;
  logic [FW-1:0]     cur_q, cur_d;
  logic [FW-1:0]     tgt_q, tgt_d;
  logic [FLOORS-1:0] pending_q, pending_d;
  logic [MCW-1:0]    move_cnt_q, move_cnt_d;
  logic [DCW-1:0]    door_cnt_q, door_cnt_d;

  logic              req_ok;
  logic              same_floor_door;
  logic [FLOORS-1:0] req_vec;
  logic [FLOORS-1:0] pend_now;
  logic [FLOORS-1:0] clr_vec;
  logic [FW-1:0]     next_up;
  logic [FW-1:0]     next_dn;
  logic              any_above;
  logic              any_below;
  logic [FW-1:0]     unused_target;
  logic              unused_above;
  logic              unused_below;

  // Direction decisions use the registered view of the car and calls.
  floor_select #(
    .FLOORS (FLOORS),
    .FW     (FW)
  ) u_sel_now (
    .pending       (pending_q),
    .current_floor (cur_q),
    .dir           (dir_q),
    .any_above     (any_above),
    .any_below     (any_below),
    .target        (unused_target)
  );

  // target_floor is registered from the next-state view so it tracks the same edge.
  floor_select #(
    .FLOORS (FLOORS),
    .FW     (FW)
  ) u_sel_next (
    .pending       (pending_d),
    .current_floor (cur_d),
    .dir           (dir_d),
    .any_above     (unused_above),
    .any_below     (unused_below),
    .target        (tgt_d)
  );

  always_comb begin
    req_ok          = req_valid && (int'(req_floor) < int'(FLOORS));
    same_floor_door = req_ok && (state_q == StDoorOpen) && (req_floor == cur_q);
    req_vec         = (req_ok && !same_floor_door) ? (FLOORS'(1) << req_floor) : '0;
    pend_now        = pending_q | req_vec;
    next_up         = cur_q + FW'(1);
    next_dn         = cur_q - FW'(1);

    state_d    = state_q;
    dir_d      = dir_q;
    cur_d      = cur_q;
    move_cnt_d = move_cnt_q;
    door_cnt_d = door_cnt_q;
    clr_vec    = '0;

    unique case (state_q)
      StIdle: begin
        if (pending_q[cur_q]) begin
          state_d    = StDoorOpen;
          door_cnt_d = '0;
          clr_vec    = FLOORS'(1) << cur_q;
        end else if (any_above && ((dir_q == DirUp) || !any_below)) begin
          state_d = StMoveUp;
          dir_d   = DirUp;
        end else if (any_below) begin
          state_d = StMoveDown;
          dir_d   = DirDown;
        end
      end

      StMoveUp: begin
        if (move_cnt_q == MoveLast) begin
          move_cnt_d = '0;
          if (int'(cur_q) >= int'(FLOORS) - 1) begin
            state_d = StIdle;
          end else begin
            cur_d = next_up;
            // A call captured on the arrival edge still stops the car.
            if (pend_now[next_up]) begin
              state_d    = StDoorOpen;
              door_cnt_d = '0;
              clr_vec    = FLOORS'(1) << next_up;
            end
          end
        end else begin
          move_cnt_d = move_cnt_q + MCW'(1);
        end
      end

      StMoveDown: begin
        if (move_cnt_q == MoveLast) begin
          move_cnt_d = '0;
          if (cur_q == '0) begin
            state_d = StIdle;
          end else begin
            cur_d = next_dn;
            if (pend_now[next_dn]) begin
              state_d    = StDoorOpen;
              door_cnt_d = '0;
              clr_vec    = FLOORS'(1) << next_dn;
            end
          end
        end else begin
          move_cnt_d = move_cnt_q + MCW'(1);
        end
      end

      StDoorOpen: begin
        if (same_floor_door) begin
          door_cnt_d = '0;
        end else if (door_cnt_q == DoorLast) begin
          door_cnt_d = '0;
          if (dir_q == DirUp) begin
            if (any_above) begin
              state_d = StMoveUp;
            end else if (any_below) begin
              state_d = StMoveDown;
              dir_d   = DirDown;
            end else begin
              state_d = StIdle;
            end
          end else begin
            if (any_below) begin
              state_d = StMoveDown;
            end else if (any_above) begin
              state_d = StMoveUp;
              dir_d   = DirUp;
            end else begin
              state_d = StIdle;
            end
          end
        end else begin
          door_cnt_d = door_cnt_q + DCW'(1);
        end
      end

      default: state_d = StIdle;
    endcase

    pending_d = pend_now & ~clr_vec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      dir_q      <= DirUp;
      cur_q      <= '0;
      tgt_q      <= '0;
      pending_q  <= '0;
      move_cnt_q <= '0;
      door_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      cur_q      <= cur_d;
      tgt_q      <= tgt_d;
      pending_q  <= pending_d;
      move_cnt_q <= move_cnt_d;
      door_cnt_q <= door_cnt_d;
    end
  end

  assign current_floor = cur_q;
  assign target_floor  = tgt_q;
  assign motor_up      = (state_q == StMoveUp);
  assign motor_down    = (state_q == StMoveDown);
  assign door_open     = (state_q == StDoorOpen);
  assign pending       = pending_q;
  assign busy          = (state_q != StIdle) || (pending_q != '0);

endmodule
